// File: rtl/hdc_projection_encoder_pkg.sv
// Shared definitions for the HDC projection encoder and its upstream generator.
// Holds the FSM state encoding, the default stream geometry (lanes per beat,
// element width, beats per pass) and the accumulator-width derivation so the
// encoder and generator agree on the same numbers.
package hdc_projection_encoder_pkg;

  localparam int DEF_ELEMENTS_PER_CLOCK = 192;
  localparam int DEF_BIT_WIDTH          = 8;
  localparam int DEF_FEAT_WIDTH         = 16;
  localparam int DEF_NUM_BEATS          = 625;

  // Product width plus enough guard bits to sum NUM_BEATS products exactly.
  function automatic int acc_width(input int bit_width, input int feat_width,
                                   input int num_beats);
    return bit_width + feat_width + $clog2(num_beats);
  endfunction

  localparam int DEF_ACC_WIDTH =
    acc_width(DEF_BIT_WIDTH, DEF_FEAT_WIDTH, DEF_NUM_BEATS);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

endpackage

// File: rtl/hdc_projection_encoder_if.sv
// Stream bundle between generator / consumer (master) and encoder (slave).
//   in_valid, data_stream[ELEMENTS_PER_CLOCK][BIT_WIDTH], gen_done : generator -> encoder
//   hv_out[ELEMENTS_PER_CLOCK], out_valid                           : encoder -> consumer
//   out_ready                                                       : consumer -> encoder
// Handshake: the input side has no ready; a beat is taken in every cycle the
// encoder is running and in_valid is high. On the output side a transfer
// happens on a rising edge where out_valid && out_ready; once out_valid is
// raised it and hv_out hold steady until that transfer.
interface hdc_projection_encoder_if
  import hdc_projection_encoder_pkg::*;
#(
  parameter int ELEMENTS_PER_CLOCK = DEF_ELEMENTS_PER_CLOCK,
  parameter int BIT_WIDTH          = DEF_BIT_WIDTH
);
  logic                                         in_valid;
  logic [ELEMENTS_PER_CLOCK-1:0][BIT_WIDTH-1:0] data_stream;
  logic                                         gen_done;
  logic [ELEMENTS_PER_CLOCK-1:0]                hv_out;
  logic                                         out_valid;
  logic                                         out_ready;

  modport master (
    output in_valid, data_stream, gen_done, out_ready,
    input  hv_out, out_valid
  );

  modport slave (
    input  in_valid, data_stream, gen_done, out_ready,
    output hv_out, out_valid
  );
endinterface

// File: rtl/hdc_projection_encoder_lane_mac.sv
// hdc_lane_mac: one signed multiply-accumulate lane.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the accumulator (takes priority over en)
//   en         : add feat*data into the accumulator this cycle
//   data, feat : signed operands
//   acc_nxt    : accumulator value including this cycle's product, so the
//                owner can capture the post-final-beat sum on the same edge
module hdc_lane_mac #(
  parameter int BIT_WIDTH  = 8,
  parameter int FEAT_WIDTH = 16,
  parameter int ACC_WIDTH  = 34
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [BIT_WIDTH-1:0]  data,
  input  logic signed [FEAT_WIDTH-1:0] feat,
  output logic signed [ACC_WIDTH-1:0]  acc_nxt
);
  localparam int PW = BIT_WIDTH + FEAT_WIDTH;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [PW-1:0]        feat_x;
  logic signed [PW-1:0]        data_x;
  logic signed [PW-1:0]        prod;

  // Operands widened explicitly so the product is computed at full precision.
  assign feat_x  = {{BIT_WIDTH{feat[FEAT_WIDTH-1]}}, feat};
  assign data_x  = {{FEAT_WIDTH{data[BIT_WIDTH-1]}}, data};
  assign prod    = feat_x * data_x;
  assign acc_nxt = acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end
endmodule

// File: rtl/hdc_projection_encoder.sv
// hdc_projection_encoder: random-projection hypervector encoder.
// Each pass consumes NUM_BEATS beats of random elements; beat b is scaled by
// feature b and summed per lane; the sign of each lane sum (positive -> 1)
// forms the binary hypervector.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a pass (only looked at in IDLE)
//   busy         : pass in progress (RUN or OUT)
//   gen_initiate : one-cycle kick to the random-element generator
//   feat_idx     : feature index wanted this cycle (= beat counter)
//   feat_data    : feature at feat_idx, same cycle
//   err          : sticky, pass aborted by an early gen_done
//   dbg_state    : current FSM state
//   bus          : stream in / hypervector out bundle (slave side)
module hdc_projection_encoder
  import hdc_projection_encoder_pkg::*;
#(
  parameter int ELEMENTS_PER_CLOCK = DEF_ELEMENTS_PER_CLOCK,
  parameter int BIT_WIDTH          = DEF_BIT_WIDTH,
  parameter int FEAT_WIDTH         = DEF_FEAT_WIDTH,
  parameter int NUM_BEATS          = DEF_NUM_BEATS,
  parameter int ACC_WIDTH          = acc_width(BIT_WIDTH, FEAT_WIDTH, NUM_BEATS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          gen_initiate,
  output logic [$clog2(NUM_BEATS)-1:0]  feat_idx,
  input  logic signed [FEAT_WIDTH-1:0]  feat_data,
  output logic                          err,
  output state_t                        dbg_state,
  hdc_projection_encoder_if.slave       bus
);
  localparam int CW = $clog2(NUM_BEATS);

  state_t                        state;
  logic [CW-1:0]                 beat_cnt;
  logic [ELEMENTS_PER_CLOCK-1:0] hv_q;
  logic [ELEMENTS_PER_CLOCK-1:0] hv_nxt;
  logic                          take_start;
  logic                          beat;
  logic                          final_beat;
  logic                          abort;

  assign take_start = (state == ST_IDLE) && start;
  assign beat       = (state == ST_RUN) && bus.in_valid;
  assign final_beat = beat && (beat_cnt == CW'(NUM_BEATS - 1));
  // A gen_done on the final beat is a normal end of sequence, not an error.
  assign abort      = (state == ST_RUN) && bus.gen_done && !final_beat;

  for (genvar k = 0; k < ELEMENTS_PER_CLOCK; k++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] acc_nxt;

    hdc_lane_mac #(
      .BIT_WIDTH (BIT_WIDTH),
      .FEAT_WIDTH(FEAT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (take_start),
      .en     (beat),
      .data   ($signed(bus.data_stream[k])),
      .feat   (feat_data),
      .acc_nxt(acc_nxt)
    );

    // Strictly positive sum -> 1; zero and negative -> 0.
    assign hv_nxt[k] = !acc_nxt[ACC_WIDTH-1] && (acc_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      gen_initiate <= 1'b0;
      err          <= 1'b0;
      hv_q         <= '0;
    end else begin
      gen_initiate <= take_start;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            beat_cnt <= '0;
            err      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (final_beat) begin
            state <= ST_OUT;
            hv_q  <= hv_nxt;
          end else if (abort) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state == ST_RUN) || (state == ST_OUT);
  assign feat_idx      = beat_cnt;
  assign dbg_state     = state;
  assign bus.hv_out    = hv_q;
  assign bus.out_valid = (state == ST_OUT);
endmodule
